// File: rtl/branch_control_sequencer.sv
// Moore control sequencer for the Mini SRC datapath: fetch (T0-T2) then br/jr/jal/nop/halt execution.
// Latency: one state per clock; br 8 cycles, jal 6, jr/nop 5, counted from T0.
// No backpressure: run starts fetching from IDLE, stop is honoured only at END, HALT holds until clr.
module branch_control_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic        stop,
   input  logic [31:0] IR_Data,
   input  logic        CON_out,
   output logic        PC_out,
   output logic        PC_in,
   output logic        IncPC,
   output logic        MAR_in,
   output logic        MDR_in,
   output logic        MDR_out,
   output logic        Read,
   output logic        IR_in,
   output logic        Y_in,
   output logic        Z_in,
   output logic        Zlow_out,
   output logic        C_out,
   output logic        Gra,
   output logic        Grb,
   output logic        Rout,
   output logic        R15_in,
   output logic        CON_in,
   output logic [4:0]  alu_instruction_bits,
   output logic        busy,
   output logic        halted,
   output logic        illegal
);

   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] ALU_ADD = 5'b00011;

   // br and jal diverge after T3, so T4 is split into two states to keep
   // the T4 strobes a function of the state register alone.
   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_T0    = 4'd1;
   localparam logic [3:0] S_T1    = 4'd2;
   localparam logic [3:0] S_T2    = 4'd3;
   localparam logic [3:0] S_T3    = 4'd4;
   localparam logic [3:0] S_T4_BR = 4'd5;
   localparam logic [3:0] S_T4_JL = 4'd6;
   localparam logic [3:0] S_T5    = 4'd7;
   localparam logic [3:0] S_T6    = 4'd8;
   localparam logic [3:0] S_END   = 4'd9;
   localparam logic [3:0] S_HALT  = 4'd10;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [4:0] opcode;
   logic       op_legal;
   logic       unused_ir;

   assign opcode    = IR_Data[31:27];
   // Operand fields belong to the datapath; the sequencer only looks at the opcode.
   assign unused_ir = ^IR_Data[26:0];

   // Classify the opcode held in IR
   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OP_BR, OP_JR, OP_JAL, OP_NOP, OP_HALT: op_legal = 1'b1;
         default:                              op_legal = 1'b0;
      endcase
   end

   // State register and sticky illegal-opcode flag; clr overrides everything
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= S_IDLE;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_T3 && !op_legal)
            illegal <= 1'b1;
      end
   end

   // Next-state sequencing; stop is only consulted at the instruction boundary
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = run ? S_T0 : S_IDLE;
         S_T0:    state_nxt = S_T1;
         S_T1:    state_nxt = S_T2;
         S_T2:    state_nxt = S_T3;
         S_T3: begin
            case (opcode)
               OP_BR:   state_nxt = S_T4_BR;
               OP_JR:   state_nxt = S_END;
               OP_JAL:  state_nxt = S_T4_JL;
               OP_NOP:  state_nxt = S_END;
               default: state_nxt = S_HALT;   // halt and unknown opcodes
            endcase
         end
         S_T4_BR: state_nxt = S_T5;
         S_T4_JL: state_nxt = S_END;
         S_T5:    state_nxt = S_T6;
         S_T6:    state_nxt = S_END;
         S_END:   state_nxt = stop ? S_IDLE : S_T0;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Strobe decode; T3 also reads the opcode and T6 the CON flip-flop, both stable by then
   always_comb begin
      PC_out               = 1'b0;
      PC_in                = 1'b0;
      IncPC                = 1'b0;
      MAR_in               = 1'b0;
      MDR_in               = 1'b0;
      MDR_out              = 1'b0;
      Read                 = 1'b0;
      IR_in                = 1'b0;
      Y_in                 = 1'b0;
      Z_in                 = 1'b0;
      Zlow_out             = 1'b0;
      C_out                = 1'b0;
      Gra                  = 1'b0;
      Grb                  = 1'b0;
      Rout                 = 1'b0;
      R15_in               = 1'b0;
      CON_in               = 1'b0;
      alu_instruction_bits = 5'b00000;
      busy                 = 1'b1;
      halted               = 1'b0;
      case (state)
         S_IDLE: busy = 1'b0;
         S_T0: begin
            PC_out = 1'b1;
            MAR_in = 1'b1;
            IncPC  = 1'b1;
            Z_in   = 1'b1;
         end
         S_T1: begin
            Zlow_out = 1'b1;
            PC_in    = 1'b1;
            Read     = 1'b1;
            MDR_in   = 1'b1;
         end
         S_T2: begin
            MDR_out = 1'b1;
            IR_in   = 1'b1;
         end
         S_T3: begin
            case (opcode)
               OP_BR: begin
                  Grb    = 1'b1;
                  Rout   = 1'b1;
                  CON_in = 1'b1;
               end
               OP_JR: begin
                  Gra   = 1'b1;
                  Rout  = 1'b1;
                  PC_in = 1'b1;
               end
               OP_JAL: begin
                  PC_out = 1'b1;
                  R15_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4_BR: begin
            PC_out = 1'b1;
            Y_in   = 1'b1;
         end
         S_T4_JL: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            PC_in = 1'b1;
         end
         S_T5: begin
            C_out                = 1'b1;
            alu_instruction_bits = ALU_ADD;
            Z_in                 = 1'b1;
         end
         S_T6: begin
            // Taken branch loads PC+1+C from Z; not-taken is an empty cycle.
            Zlow_out = CON_out;
            PC_in    = CON_out;
         end
         S_END: ;
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_branch_control_sequencer.sv
// Randomised bench for branch_control_sequencer: per-instruction microprogram model feeds a scoreboard.
// Stimulus pushes the expected control word for each cycle; a negedge monitor pops and compares.
// The sequencer has no backpressure; the monitor compares every cycle that has an expectation.
module tb_branch_control_sequencer;

   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef logic [24:0] vec_t;
   // Control word layout, MSB first, matching the concatenation into act below
   localparam vec_t V_PCO  = vec_t'(1) << 24;
   localparam vec_t V_PCI  = vec_t'(1) << 23;
   localparam vec_t V_INC  = vec_t'(1) << 22;
   localparam vec_t V_MAR  = vec_t'(1) << 21;
   localparam vec_t V_MDRI = vec_t'(1) << 20;
   localparam vec_t V_MDRO = vec_t'(1) << 19;
   localparam vec_t V_RD   = vec_t'(1) << 18;
   localparam vec_t V_IRI  = vec_t'(1) << 17;
   localparam vec_t V_YIN  = vec_t'(1) << 16;
   localparam vec_t V_ZIN  = vec_t'(1) << 15;
   localparam vec_t V_ZLO  = vec_t'(1) << 14;
   localparam vec_t V_COUT = vec_t'(1) << 13;
   localparam vec_t V_GRA  = vec_t'(1) << 12;
   localparam vec_t V_GRB  = vec_t'(1) << 11;
   localparam vec_t V_ROUT = vec_t'(1) << 10;
   localparam vec_t V_R15  = vec_t'(1) << 9;
   localparam vec_t V_CONI = vec_t'(1) << 8;
   localparam vec_t V_ADD  = vec_t'(3) << 3;
   localparam vec_t V_BUSY = vec_t'(1) << 2;
   localparam vec_t V_HLT  = vec_t'(1) << 1;
   localparam vec_t V_ILL  = vec_t'(1);

   logic        clk = 1'b0;
   logic        clr, run, stop, CON_out;
   logic [31:0] IR_Data;
   logic        PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in, Y_in, Z_in;
   logic        Zlow_out, C_out, Gra, Grb, Rout, R15_in, CON_in, busy, halted, illegal;
   logic [4:0]  alu_instruction_bits;
   vec_t        act;

   vec_t  sb_q[$];
   int    tag_q[$];
   vec_t  prog[$];
   int    vectors    = 0;
   int    miscompares = 0;
   int    instr_no   = 0;
   bit    in_idle;

   always #5 clk = ~clk;

   branch_control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .stop(stop), .IR_Data(IR_Data), .CON_out(CON_out),
      .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in), .MDR_in(MDR_in),
      .MDR_out(MDR_out), .Read(Read), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
      .Zlow_out(Zlow_out), .C_out(C_out), .Gra(Gra), .Grb(Grb), .Rout(Rout),
      .R15_in(R15_in), .CON_in(CON_in), .alu_instruction_bits(alu_instruction_bits),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   assign act = {PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in, Y_in, Z_in,
                 Zlow_out, C_out, Gra, Grb, Rout, R15_in, CON_in, alu_instruction_bits,
                 busy, halted, illegal};

   // Monitor: one expected control word per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         vec_t exp_v;
         int   tag;
         exp_v = sb_q.pop_front();
         tag   = tag_q.pop_front();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL ctl_word instr=%0d actual=%h required=%h", tag, act, exp_v);
         end
      end
   end

   function automatic bit is_legal(input logic [4:0] op);
      return op == OP_BR || op == OP_JR || op == OP_JAL || op == OP_NOP || op == OP_HALT;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Apply one cycle of inputs and record what the sequencer must show this cycle
   task automatic cyc(input vec_t v, input logic r, input logic s, input logic c,
                      input logic [31:0] ir, input logic con);
      run     = r;
      stop    = s;
      clr     = c;
      IR_Data = ir;
      CON_out = con;
      sb_q.push_back(v);
      tag_q.push_back(instr_no);
      @(posedge clk);
      #1;
   endtask

   // Microprogram of one instruction from T0 to its last busy cycle
   task automatic build(input logic [4:0] op, input logic con);
      prog.delete();
      prog.push_back(V_BUSY | V_PCO | V_MAR | V_INC | V_ZIN);
      prog.push_back(V_BUSY | V_ZLO | V_PCI | V_RD | V_MDRI);
      prog.push_back(V_BUSY | V_MDRO | V_IRI);
      if (op == OP_BR) begin
         prog.push_back(V_BUSY | V_GRB | V_ROUT | V_CONI);
         prog.push_back(V_BUSY | V_PCO | V_YIN);
         prog.push_back(V_BUSY | V_COUT | V_ADD | V_ZIN);
         prog.push_back(con ? (V_BUSY | V_ZLO | V_PCI) : V_BUSY);
         prog.push_back(V_BUSY);
      end else if (op == OP_JR) begin
         prog.push_back(V_BUSY | V_GRA | V_ROUT | V_PCI);
         prog.push_back(V_BUSY);
      end else if (op == OP_JAL) begin
         prog.push_back(V_BUSY | V_PCO | V_R15);
         prog.push_back(V_BUSY | V_GRA | V_ROUT | V_PCI);
         prog.push_back(V_BUSY);
      end else if (op == OP_NOP) begin
         prog.push_back(V_BUSY);
         prog.push_back(V_BUSY);
      end else begin
         prog.push_back(V_BUSY);   // decode cycle before halting
      end
   endtask

   // Run one instruction; abort >= 0 pulses clr during that microprogram step
   task automatic do_instr(input logic [4:0] op, input logic con, input logic stop_end,
                           input int abort);
      logic [31:0] instr;
      bit          stops_machine;
      vec_t        hv;
      instr_no++;
      instr = {op, 27'($urandom)};
      stops_machine = !is_legal(op) || op == OP_HALT;
      build(op, con);
      if (in_idle) begin
         repeat ($urandom_range(0, 2)) cyc('0, 1'b0, rbit(), 1'b0, $urandom, rbit());
         cyc('0, 1'b1, rbit(), 1'b0, $urandom, rbit());
      end
      for (int k = 0; k < prog.size(); k++) begin
         logic st, ck, cn;
         st = (k == prog.size() - 1 && !stops_machine) ? stop_end : rbit();
         ck = (k == abort);
         cn = (k == 6 && op == OP_BR) ? con : rbit();
         cyc(prog[k], rbit(), st, ck, (k >= 3) ? instr : $urandom, cn);
         if (ck) begin
            in_idle = 1'b1;
            return;
         end
      end
      if (stops_machine) begin
         hv = V_HLT | (is_legal(op) ? vec_t'(0) : V_ILL);
         repeat ($urandom_range(10, 14)) cyc(hv, 1'b1, rbit(), 1'b0, $urandom, rbit());
         cyc(hv, rbit(), rbit(), 1'b1, $urandom, rbit());
         in_idle = 1'b1;
      end else begin
         in_idle = stop_end;
      end
   endtask

   initial begin
      logic [4:0] op;
      int         sel;
      clr = 1'b1; run = 1'b0; stop = 1'b0; IR_Data = '0; CON_out = 1'b0;
      @(posedge clk);
      #1;
      cyc('0, 1'b1, rbit(), 1'b1, $urandom, rbit());
      cyc('0, 1'b0, rbit(), 1'b0, $urandom, rbit());
      in_idle = 1'b1;

      do_instr(OP_BR,    1'b1, 1'b0, -1);   // taken branch, back-to-back fetch
      do_instr(OP_BR,    1'b0, 1'b0, -1);   // not taken
      do_instr(OP_JAL,   1'b0, 1'b0, -1);
      do_instr(OP_JR,    1'b0, 1'b0, -1);
      do_instr(OP_NOP,   1'b0, 1'b1, -1);   // stop at END returns to IDLE
      do_instr(OP_BR,    1'b1, 1'b0, 5);    // clr during T5
      do_instr(5'b11111, 1'b0, 1'b0, -1);   // illegal opcode
      do_instr(OP_NOP,   1'b0, 1'b0, -1);
      do_instr(OP_HALT,  1'b0, 1'b0, -1);

      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 19);
         if (sel < 6)       op = OP_BR;
         else if (sel < 9)  op = OP_JR;
         else if (sel < 12) op = OP_JAL;
         else if (sel < 17) op = OP_NOP;
         else if (sel < 18) op = OP_HALT;
         else begin
            op = 5'($urandom);
            while (is_legal(op)) op = 5'($urandom);
         end
         do_instr(op, rbit(), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
      end

      repeat (2) @(posedge clk);
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
